arith_share_arbiter: RTL
========================

# arith_share_arbiter

Shares one 4-bit arithmetic/compare datapath (add, subtract, compare) between two requesters. Each requester presents an operation with operands through a valid/ready handshake. The block grants the datapath round-robin, sequences each operation through a small FSM, and returns registered results on a single tagged response channel. It sits between requester logic and the `arith_compare_top` datapath.

## Interface
- No parameters. Widths are fixed: operands 4-bit, op 2-bit, result 4-bit, flags 3-bit.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester accept; a transfer happens on `req_valid[i] & req_ready[i]`.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  4 each  operands.
- `req0_op`, `req1_op`  in  2 each  operation select:
  - 00 add
  - 01 subtract
  - 10 compare
  - 11 nop
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  1  index of the requester that owns the response.
- `rsp_result`  out  4  result nibble.
- `rsp_flag`  out  3  compare flags: bit 2 = A>B, bit 1 = A==B, bit 0 = A<B.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done_count`  out  8  count of completed responses; wraps 255→0.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:**
  - `req_ready[0] = req_valid[0] & (~req_valid[1] | last_grant==1)`.
  - `req_ready[1] = req_valid[1] & (~req_valid[0] | last_grant==0)`.
  - At most one ready bit is high at a time.
  - On a handshake: latch that requester's a, b, op and id into operand registers, set `last_grant` to the id, and go to EXEC.
- **EXEC:**
  - Operand registers drive the datapath.
  - Capture the datapath result and flags into the response registers, then go to RESP.
  - `req_ready` is 00.
- **RESP:**
  - `rsp_valid` = 1; `rsp_id`, `rsp_result` and `rsp_flag` are held stable.
  - On `rsp_ready`: increment `done_count` and go to IDLE.
  - `req_ready` is 00.
- **Arithmetic:**
  - Add and subtract are modulo 16; carry and borrow are discarded.
  - Compare result is `{1'b0, gt, eq, lt}`.
  - Nop result is 0000.
  - `rsp_flag` always carries the compare flags of the latched operands, whatever the op.
- A requester's `req_valid` must not depend on `req_ready`. Operands must stay stable while valid is high and not yet accepted. The block does not check this.
- `req_ready` depends combinationally on `req_valid`. No other combinational input-to-output path exists.

## Timing
- **Reset values:**
  - State = IDLE, `last_grant` = 1, so requester 0 wins the first contention.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_flag` = 000, `busy` = 0, `done_count` = 0.
- **Latency:** handshake in cycle n → EXEC in n+1 → `rsp_valid` high from cycle n+2.
- **Throughput:** with `rsp_ready` tied high, the block is back in IDLE in n+3 and can accept again there. That gives at most one operation per 3 cycles.
- **Contention:** with both valids held high continuously, grants alternate 0,1,0,1…
- **Single requester:** with one requester only, it is granted every IDLE cycle regardless of `last_grant`.
- **Backpressure:** while `rsp_ready` = 0 in RESP, all response outputs are frozen and no new request is accepted.
- **Reset mid-operation** (in EXEC or RESP):
  - The transaction is dropped and no response is produced.
  - `rsp_valid` reads 0 in the cycle after `rst` is sampled.
  - `done_count` returns to 0.
- `done_count` increments exactly on the `rsp_valid & rsp_ready` cycle edge.

## Structure
- Shared package `arith_ctrl_pkg` holds:
  - op encodings: `OP_ADD` = 2'b00, `OP_SUB` = 2'b01, `OP_CMP` = 2'b10, `OP_NOP` = 2'b11;
  - FSM state encoding (IDLE, EXEC, RESP);
  - flag bit-index constants: `FLAG_GT` = 2, `FLAG_EQ` = 1, `FLAG_LT` = 0.
- One sub-module: the existing `arith_compare_top` datapath, instantiated once. Its `ctrl` input is driven by the latched op.
- The round-robin grant logic is small enough to stay inline.

## Test plan
- **Add:** requester 0 sends A=9, B=5, op 00; `rsp_ready` = 1. Required: `rsp_valid` rises 2 cycles after the handshake with `rsp_id` = 0, `rsp_result` = 1110, `rsp_flag` = 100. `done_count` then reads 1.
- **Subtract wrap:** requester 1 sends A=3, B=5, op 01. Required: `rsp_id` = 1, `rsp_result` = 1110, `rsp_flag` = 001.
- **Compare and nop:**
  - A=7, B=7, op 10 → `rsp_result` = 0010, `rsp_flag` = 010.
  - A=7, B=7, op 11 → `rsp_result` = 0000, `rsp_flag` = 010.
- **Contention:**
  - Drive both requesters valid right after reset for 4 transactions. Required: grant order 0,1,0,1, with a 3-cycle spacing between handshakes.
  - Then drop requester 1. Required: requester 0 is granted on consecutive transactions.
- **Backpressure:** hold `rsp_ready` = 0 for 4 cycles in RESP. Required: response outputs stable, `req_ready` = 00, `busy` = 1. After `rsp_ready` is released: exactly one `done_count` increment.
- **Reset in EXEC:** assert `rst` for 1 cycle. Required: no response ever appears for that request, `rsp_valid`/`busy`/`done_count` read 0, and the next contention grants requester 0 first.

Source files
------------

// File: rtl/arith_ctrl_pkg.sv
// arith_ctrl_pkg: op encodings, FSM states and flag bit positions shared by the arbiter and datapath
package arith_ctrl_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;
  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/arith_compare_top.sv
// arith_compare_top: combinational 4-bit add/subtract/compare datapath with compare flags
module arith_compare_top
  import arith_ctrl_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [1:0] i_ctrl,
  output logic [3:0] o_result,
  output logic [2:0] o_flags
);
  // flags are always produced; result is chosen by the op, carry/borrow dropped
  always_comb begin
    o_flags = '0;
    o_flags[FLAG_GT] = i_a > i_b;
    o_flags[FLAG_EQ] = i_a == i_b;
    o_flags[FLAG_LT] = i_a < i_b;
    o_result = i_ctrl == OP_ADD ? i_a + i_b :
               i_ctrl == OP_SUB ? i_a - i_b :
               i_ctrl == OP_CMP ? {1'b0, o_flags} : 4'd0;
  end
endmodule

// File: rtl/arith_share_arbiter.sv
// arith_share_arbiter: round-robin sharing of one arithmetic datapath between two requesters
module arith_share_arbiter
  import arith_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_flag,
  output logic       busy,
  output logic [7:0] done_count
);
  state_t     r_state;
  state_t     w_next;
  logic       r_last_grant;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [1:0] r_op;
  logic       r_id;
  logic       w_sel;
  logic [3:0] w_result;
  logic [2:0] w_flags;

  arith_compare_top u_dp (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_ctrl   (r_op),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  assign w_sel     = req_ready[1];
  assign rsp_valid = r_state == ST_RESP;
  assign busy      = r_state != ST_IDLE;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  // grant only in IDLE; the requester not granted last time wins a tie
  always_comb begin
    req_ready = '0;
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        req_ready[0] = req_valid[0] & (~req_valid[1] | r_last_grant);
        req_ready[1] = req_valid[1] & (~req_valid[0] | ~r_last_grant);
        w_next = |(req_valid & req_ready) ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: w_next = rsp_ready ? ST_IDLE : ST_RESP;
      default: w_next = ST_IDLE;
    endcase
  end

  // operand capture on grant, response capture in EXEC, completion counting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= OP_NOP;
      r_id         <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_flag     <= '0;
      done_count   <= '0;
    end else begin
      if (r_state == ST_IDLE && |req_ready) begin
        r_id         <= w_sel;
        r_last_grant <= w_sel;
        r_a          <= w_sel ? req1_a : req0_a;
        r_b          <= w_sel ? req1_b : req0_b;
        r_op         <= w_sel ? req1_op : req0_op;
      end
      if (r_state == ST_EXEC) begin
        rsp_id     <= r_id;
        rsp_result <= w_result;
        rsp_flag   <= w_flags;
      end
      if (rsp_valid && rsp_ready) done_count <= done_count + 8'd1;
    end
  end
endmodule
